// File: rtl/field_vga_renderer.sv
// field_vga_renderer
//
// Display stage for the cellular field. It scans the field RAM that is
// currently on display in raster order, generates VGA timing, and draws each
// cell as a CELL_PX x CELL_PX square of 2-bit pixel codes for the colour
// encoder.
//
// The pipeline has two stages:
//   stage 0: h/v counters plus the sub-cell and cell counters. The RAM
//            address, read enable and vblank come straight from these.
//   stage 1: registered video outputs (de, syncs, pixel code), one tick
//            behind stage 0. The RAM returns data within one clk, so the
//            cell state for the stage-0 address is valid at the next tick.
// Every register advances only on clk edges where i_pix_en=1.
//
// Optional build macro:
//   FIELD_VGA_GRID_LINES_EN - when defined, in-field pixels on the first row
//   or column of a cell (sub_y==0 or sub_x==0) produce code 11 (grid line).
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   i_pix_en         pixel tick (clock enable)
//   o_rd_en          stage-0 pixel lies inside the field area
//   o_rd_x, o_rd_y   cell address to the field RAM
//   i_rd_cell        cell state returned by the field RAM
//   o_hsync, o_vsync active-low syncs (stage 1)
//   o_de             display enable (stage 1)
//   o_pixel_code     00 background, 01 dead, 10 live, 11 grid (stage 1)
//   o_vblank         stage-0 line is outside active video; field swap is safe
//   o_frame_start    high for the clk whose tick wraps the scan to (0,0)
module field_vga_renderer #(
  parameter int FIELD_W  = 64,
  parameter int FIELD_H  = 48,
  parameter int CELL_PX  = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_pix_en,
  output logic                       o_rd_en,
  output logic [$clog2(FIELD_W)-1:0] o_rd_x,
  output logic [$clog2(FIELD_H)-1:0] o_rd_y,
  input  logic                       i_rd_cell,
  output logic                       o_hsync,
  output logic                       o_vsync,
  output logic                       o_de,
  output logic [1:0]                 o_pixel_code,
  output logic                       o_vblank,
  output logic                       o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int SW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int XW = $clog2(FIELD_W);
  localparam int YW = $clog2(FIELD_H);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [HW-1:0] FX_END   = HW'(FIELD_W * CELL_PX);
  localparam logic [VW-1:0] FY_END   = VW'(FIELD_H * CELL_PX);
  localparam logic [SW-1:0] S_LAST   = SW'(CELL_PX - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(FIELD_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(FIELD_H - 1);

  // The field must fit inside the active picture.
  if (FIELD_W * CELL_PX > H_ACTIVE) begin : g_field_w_err
    $error("field_vga_renderer: FIELD_W*CELL_PX exceeds H_ACTIVE");
  end
  if (FIELD_H * CELL_PX > V_ACTIVE) begin : g_field_h_err
    $error("field_vga_renderer: FIELD_H*CELL_PX exceeds V_ACTIVE");
  end

  // Stage 0 scan state
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [SW-1:0] sub_x, sub_y;
  logic [XW-1:0] cell_x;
  logic [YW-1:0] cell_y;

  logic h_wrap, v_wrap;
  logic in_active, in_hsync, in_vsync;
  logic [1:0] pixel_next;

  assign h_wrap    = (h_cnt == H_LAST);
  assign v_wrap    = (v_cnt == V_LAST);
  assign in_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign in_hsync  = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
  assign in_vsync  = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);

  assign o_rd_en  = (h_cnt < FX_END) && (v_cnt < FY_END);
  assign o_rd_x   = cell_x;
  assign o_rd_y   = cell_y;
  assign o_vblank = (v_cnt >= V_ACT);
  // Decoded from stage 0 so the pulse sits exactly on the wrapping tick.
  assign o_frame_start = i_pix_en && h_wrap && v_wrap;

  // Pixel code for the stage-0 pixel; i_rd_cell already reflects its address.
  always_comb begin
    pixel_next = 2'b00;
    if (in_active && o_rd_en) begin
`ifdef FIELD_VGA_GRID_LINES_EN
      if ((sub_x == '0) || (sub_y == '0)) pixel_next = 2'b11;
      else if (i_rd_cell)                 pixel_next = 2'b10;
      else                                pixel_next = 2'b01;
`else
      pixel_next = i_rd_cell ? 2'b10 : 2'b01;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      sub_x        <= '0;
      sub_y        <= '0;
      cell_x       <= '0;
      cell_y       <= '0;
      o_de         <= 1'b0;
      o_hsync      <= 1'b1;
      o_vsync      <= 1'b1;
      o_pixel_code <= 2'b00;
    end else if (i_pix_en) begin
      // Stage 1 captures the current stage-0 pixel.
      o_de         <= in_active;
      o_hsync      <= ~in_hsync;
      o_vsync      <= ~in_vsync;
      o_pixel_code <= pixel_next;

      if (h_wrap) begin
        h_cnt  <= '0;
        sub_x  <= '0;
        cell_x <= '0;
        if (v_wrap) begin
          v_cnt  <= '0;
          sub_y  <= '0;
          cell_y <= '0;
        end else begin
          v_cnt <= v_cnt + 1'b1;
          if (sub_y == S_LAST) begin
            sub_y <= '0;
            // Saturate so lines below the field keep a legal row address.
            if (cell_y != Y_LAST) cell_y <= cell_y + 1'b1;
          end else begin
            sub_y <= sub_y + 1'b1;
          end
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
        if (sub_x == S_LAST) begin
          sub_x <= '0;
          if (cell_x != X_LAST) cell_x <= cell_x + 1'b1;
        end else begin
          sub_x <= sub_x + 1'b1;
        end
      end
    end
  end

endmodule
